// File: rtl/burst_write_master.sv
// ---------------------------------------------------------------------------
// burst_write_master
//
// Streams up to 2**BUF_AW words from a small local register buffer onto a
// burst-capable write bus as a single burst.
//
// Ports:
//   clk, reset            : clock (rising edge) and asynchronous active-high reset
//   master_address        : burst start address, constant for the whole burst
//   master_write          : write request, held high until the last beat is taken
//   master_writedata      : data of the current beat
//   master_burstcount     : number of beats in the burst
//   master_byteenable     : always all ones
//   master_waitrequest    : slave stall; a beat is taken when write=1 and this is 0
//   ctrl_write            : buffer load strobe (ignored while busy)
//   ctrl_address          : buffer load index
//   ctrl_writedata        : buffer load data
//   ctrl_start            : level start request
//   ctrl_baseaddress      : burst target address, sampled at start
//   ctrl_burstcount       : requested beats, sampled at start, clamped to depth
//   ctrl_busy             : burst in progress
//   ctrl_done             : burst complete, held until ctrl_start drops
// ---------------------------------------------------------------------------
module burst_write_master #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int BURST_WIDTH   = 4,
    parameter int BUF_AW        = 3
) (
    input  logic                      clk,
    input  logic                      reset,
    output logic [ADDRESS_WIDTH-1:0]  master_address,
    output logic                      master_write,
    output logic [DATA_WIDTH-1:0]     master_writedata,
    output logic [BURST_WIDTH-1:0]    master_burstcount,
    output logic [DATA_WIDTH/8-1:0]   master_byteenable,
    input  logic                      master_waitrequest,
    input  logic                      ctrl_write,
    input  logic [BUF_AW-1:0]         ctrl_address,
    input  logic [DATA_WIDTH-1:0]     ctrl_writedata,
    input  logic                      ctrl_start,
    input  logic [ADDRESS_WIDTH-1:0]  ctrl_baseaddress,
    input  logic [BURST_WIDTH-1:0]    ctrl_burstcount,
    output logic                      ctrl_busy,
    output logic                      ctrl_done
);

    localparam int DEPTH = 2 ** BUF_AW;

    typedef enum logic [2:0] {
        IDLE  = 3'b001,
        BURST = 3'b010,
        DONE  = 3'b100
    } state_t;

    state_t                 state;
    logic [DATA_WIDTH-1:0]  buf_mem [DEPTH];
    logic [BUF_AW:0]        n_lat;      // clamped beat count of current burst
    logic [BUF_AW:0]        beat;       // index of the beat currently on the bus
    logic [BUF_AW:0]        n_req;
    logic [BUF_AW:0]        last_beat;
    logic [BUF_AW-1:0]      next_idx;
    logic                   accepted;

    // Requested count limited to the buffer depth; counts above it send the
    // whole buffer once rather than wrapping.
    function automatic logic [BUF_AW:0] clamp_count(input logic [BURST_WIDTH-1:0] c);
        if (32'(c) > DEPTH)
            return (BUF_AW+1)'(DEPTH);
        else
            return (BUF_AW+1)'(c);
    endfunction

    assign n_req             = clamp_count(ctrl_burstcount);
    assign last_beat         = n_lat - 1'b1;
    assign next_idx          = beat[BUF_AW-1:0] + 1'b1;
    assign accepted          = master_write && !master_waitrequest;
    assign master_byteenable = '1;

    // Buffer load port. Locked while a burst is running so the data being
    // streamed cannot change under the bus.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++)
                buf_mem[i] <= '0;
        end else if (ctrl_write && !ctrl_busy) begin
            buf_mem[ctrl_address] <= ctrl_writedata;
        end
    end

    // Control FSM with registered bus outputs. The first beat is read from
    // the buffer on the start edge, so a same-edge load of entry 0 is not seen
    // by beat 0; loads of other entries land before they are read.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state             <= IDLE;
            master_address    <= '0;
            master_write      <= 1'b0;
            master_writedata  <= '0;
            master_burstcount <= '0;
            ctrl_busy         <= 1'b0;
            ctrl_done         <= 1'b0;
            n_lat             <= '0;
            beat              <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (ctrl_start) begin
                        n_lat <= n_req;
                        beat  <= '0;
                        if (n_req == '0) begin
                            ctrl_done <= 1'b1;
                            state     <= DONE;
                        end else begin
                            master_address    <= ctrl_baseaddress;
                            master_burstcount <= BURST_WIDTH'(n_req);
                            master_write      <= 1'b1;
                            master_writedata  <= buf_mem[0];
                            ctrl_busy         <= 1'b1;
                            state             <= BURST;
                        end
                    end
                end

                BURST: begin
                    // Under waitrequest nothing moves; all outputs hold.
                    if (accepted) begin
                        if (beat == last_beat) begin
                            master_write <= 1'b0;
                            ctrl_busy    <= 1'b0;
                            ctrl_done    <= 1'b1;
                            state        <= DONE;
                        end else begin
                            beat             <= beat + 1'b1;
                            master_writedata <= buf_mem[next_idx];
                        end
                    end
                end

                DONE: begin
                    // Start is a level: require it low before another burst.
                    if (!ctrl_start) begin
                        ctrl_done <= 1'b0;
                        state     <= IDLE;
                    end
                end

                default: begin
                    master_write <= 1'b0;
                    ctrl_busy    <= 1'b0;
                    ctrl_done    <= 1'b0;
                    state        <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_burst_write_master.sv
// ---------------------------------------------------------------------------
// tb_burst_write_master
//
// Table-driven bench for burst_write_master: each record describes one burst
// (count, address, stall pattern, side loads) and the number of beats it must
// produce. Expected beats go into a scoreboard queue when the burst is started
// and are popped as the DUT presents them on the bus.
// ---------------------------------------------------------------------------
module tb_burst_write_master;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BW = 4;
    localparam int BA = 3;

    logic            clk;
    logic            reset;
    logic [AW-1:0]   master_address;
    logic            master_write;
    logic [DW-1:0]   master_writedata;
    logic [BW-1:0]   master_burstcount;
    logic [DW/8-1:0] master_byteenable;
    logic            master_waitrequest;
    logic            ctrl_write;
    logic [BA-1:0]   ctrl_address;
    logic [DW-1:0]   ctrl_writedata;
    logic            ctrl_start;
    logic [AW-1:0]   ctrl_baseaddress;
    logic [BW-1:0]   ctrl_burstcount;
    logic            ctrl_busy;
    logic            ctrl_done;

    burst_write_master #(
        .ADDRESS_WIDTH(AW),
        .DATA_WIDTH   (DW),
        .BURST_WIDTH  (BW),
        .BUF_AW       (BA)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .master_address    (master_address),
        .master_write      (master_write),
        .master_writedata  (master_writedata),
        .master_burstcount (master_burstcount),
        .master_byteenable (master_byteenable),
        .master_waitrequest(master_waitrequest),
        .ctrl_write        (ctrl_write),
        .ctrl_address      (ctrl_address),
        .ctrl_writedata    (ctrl_writedata),
        .ctrl_start        (ctrl_start),
        .ctrl_baseaddress  (ctrl_baseaddress),
        .ctrl_burstcount   (ctrl_burstcount),
        .ctrl_busy         (ctrl_busy),
        .ctrl_done         (ctrl_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [BW-1:0] bc;
    } beat_t;

    typedef struct {
        int            count;    // value driven on ctrl_burstcount
        logic [AW-1:0] base;
        int            sa;       // first stalled beat (-1 none)
        int            sb;       // second stalled beat (-1 none)
        int            sl;       // stall cycles per stalled beat
        int            hold;     // extra cycles ctrl_start stays high after done
        bit            busy_wr;  // attempt a load of entry 2 while busy
        bit            sw_en;    // load a buffer entry on the start edge
        int            sw_idx;
        logic [DW-1:0] sw_data;
        int            exp;      // beats the burst must produce
    } vec_t;

    beat_t         sb_q[$];
    logic [DW-1:0] model_buf [8];
    vec_t          vecs [8];
    int            errors = 0;
    int            checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic load(input int idx, input logic [DW-1:0] data);
        ctrl_write     = 1'b1;
        ctrl_address   = BA'(idx);
        ctrl_writedata = data;
        @(posedge clk); #1;
        ctrl_write     = 1'b0;
        model_buf[idx] = data;
    endtask

    task automatic run_burst(input vec_t v);
        beat_t b;
        int    accepted;
        int    held;
        int    guard;
        bit    stall;
        if (v.sw_en && v.sw_idx != 0) model_buf[v.sw_idx] = v.sw_data;
        for (int i = 0; i < v.exp; i++) begin
            b.addr = v.base;
            b.bc   = BW'(v.exp);
            b.data = model_buf[i];
            sb_q.push_back(b);
        end
        if (v.sw_en && v.sw_idx == 0) model_buf[0] = v.sw_data;

        ctrl_start       = 1'b1;
        ctrl_baseaddress = v.base;
        ctrl_burstcount  = BW'(v.count);
        if (v.sw_en) begin
            ctrl_write     = 1'b1;
            ctrl_address   = BA'(v.sw_idx);
            ctrl_writedata = v.sw_data;
        end
        @(posedge clk); #1;
        ctrl_write       = 1'b0;
        ctrl_baseaddress = ~v.base;           // must not disturb the running burst
        ctrl_burstcount  = BW'(v.count + 5);
        chk("busy_after_start", ctrl_busy, v.exp > 0);

        accepted = 0;
        held     = 0;
        guard    = 0;
        while (accepted < v.exp && guard < 200) begin
            stall = (accepted == v.sa || accepted == v.sb) && held < v.sl;
            master_waitrequest = stall;
            if (v.busy_wr && guard == 0) begin
                ctrl_write     = 1'b1;
                ctrl_address   = 3'd2;
                ctrl_writedata = 32'h0000_0055;
            end
            @(negedge clk);
            chk("write_continuous", master_write, 1'b1);
            chk("address", master_address, sb_q[0].addr);
            chk("burstcount", master_burstcount, sb_q[0].bc);
            chk(stall ? "data_held_in_stall" : "beat_data", master_writedata, sb_q[0].data);
            if (stall) begin
                held++;
            end else begin
                void'(sb_q.pop_front());
                accepted++;
                held = 0;
            end
            @(posedge clk); #1;
            ctrl_write = 1'b0;
            guard++;
        end
        if (guard >= 200) begin
            checks++;
            errors++;
            $display("FAIL burst_timeout actual=%0d beats required=%0d", accepted, v.exp);
        end
        master_waitrequest = 1'b0;

        @(negedge clk);
        chk("write_low_after", master_write, 1'b0);
        chk("done_after", ctrl_done, 1'b1);
        chk("busy_low_after", ctrl_busy, 1'b0);
        chk("scoreboard_empty", sb_q.size(), 0);
        for (int i = 0; i < v.hold; i++) begin
            @(negedge clk);
            chk("no_second_burst", master_write, 1'b0);
            chk("done_held", ctrl_done, 1'b1);
        end
        @(posedge clk); #1;
        ctrl_start = 1'b0;
        @(posedge clk); #1;
        chk("done_cleared", ctrl_done, 1'b0);
        chk("busy_idle", ctrl_busy, 1'b0);
        sb_q.delete();
    endtask

    function automatic vec_t mk(input int count, input logic [AW-1:0] base,
                                input int sa, input int sb, input int sl, input int hold,
                                input bit busy_wr, input bit sw_en, input int sw_idx,
                                input logic [DW-1:0] sw_data, input int exp);
        vec_t v;
        v.count = count;  v.base = base;  v.sa = sa;  v.sb = sb;  v.sl = sl;
        v.hold = hold;    v.busy_wr = busy_wr;  v.sw_en = sw_en;
        v.sw_idx = sw_idx;  v.sw_data = sw_data;  v.exp = exp;
        return v;
    endfunction

    initial begin
        vec_t rv;
        vecs[0] = mk( 8, 32'h3900_0000, -1, -1, 0, 0, 0, 0, 0, 32'h0,  8); // plain full burst
        vecs[1] = mk( 8, 32'h3900_0000,  0,  5, 3, 4, 0, 0, 0, 32'h0,  8); // stalls, start held
        vecs[2] = mk( 0, 32'h0000_1234, -1, -1, 0, 2, 0, 0, 0, 32'h0,  0); // zero count
        vecs[3] = mk(12, 32'h0000_4000, -1, -1, 0, 0, 1, 0, 0, 32'h0,  8); // clamp + busy load
        vecs[4] = mk( 4, 32'h0000_1000,  2, -1, 1, 0, 0, 0, 0, 32'h0,  4); // entry 2 unchanged
        vecs[5] = mk( 3, 32'h0000_2000, -1, -1, 0, 0, 0, 1, 0, 32'hB0, 3); // same-edge load idx 0
        vecs[6] = mk( 5, 32'h0000_3000,  3, -1, 2, 0, 0, 1, 3, 32'hB3, 5); // same-edge load idx 3
        vecs[7] = mk( 1, 32'hFFFF_FFF0, -1, -1, 0, 0, 0, 0, 0, 32'h0,  1); // single beat

        reset              = 1'b1;
        master_waitrequest = 1'b0;
        ctrl_write         = 1'b0;
        ctrl_address       = '0;
        ctrl_writedata     = '0;
        ctrl_start         = 1'b0;
        ctrl_baseaddress   = '0;
        ctrl_burstcount    = '0;
        for (int i = 0; i < 8; i++) model_buf[i] = '0;
        #1;
        chk("rst_address", master_address, 0);
        chk("rst_write", master_write, 0);
        chk("rst_writedata", master_writedata, 0);
        chk("rst_burstcount", master_burstcount, 0);
        chk("rst_busy", ctrl_busy, 0);
        chk("rst_done", ctrl_done, 0);
        chk("byteenable", master_byteenable, 4'hF);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 8; i++) load(i, 32'hA0 + i);

        for (int i = 0; i < 8; i++) run_burst(vecs[i]);

        // Abort mid-burst: reset with beat 3 on the bus.
        ctrl_start       = 1'b1;
        ctrl_baseaddress = 32'h3900_0000;
        ctrl_burstcount  = 4'd8;
        @(posedge clk); #1;
        repeat (3) @(posedge clk);
        #1;
        chk("pre_reset_beat3", master_writedata, model_buf[3]);
        reset = 1'b1;
        #1;
        chk("abort_write", master_write, 0);
        chk("abort_busy", ctrl_busy, 0);
        chk("abort_done", ctrl_done, 0);
        chk("abort_address", master_address, 0);
        ctrl_start = 1'b0;
        @(negedge clk);
        chk("abort_no_beats", master_write, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        for (int i = 0; i < 8; i++) model_buf[i] = '0;
        @(posedge clk); #1;
        rv = mk(8, 32'h0000_8000, -1, -1, 0, 0, 0, 0, 0, 32'h0, 8);
        run_burst(rv);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
